sampdecim: RTL and testbench

Per-channel sample decimator placed between an `adcchannel` sample output and the `sampselect` source input. It reduces the 32-bit packed sample stream (four unsigned 8-bit ADC bytes per word) by a programmable factor, either by picking every Nth word or by lane-wise averaging. This lowers the effective capture rate so the fixed-size sample queue covers a longer time window. Configuration is over the same 8-bit wishbone slave bus used by the other channel blocks, at its own slot in `busdispatch`.

---
 rtl/sampdecim.sv | 171 +++++++++++++++++
 tb/tb_sampdecim.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampdecim.sv
// sampdecim: per-channel sample decimator (pass, pick-every-Nth, lane average)
// with shadowed wishbone config captured on each capture-active rise.
module sampdecim #(
  parameter int ACC_BITS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sq_active,
  input  logic [31:0] sample_in,
  input  logic        sample_in_avail,
  output logic [31:0] sample,
  output logic        sample_avail,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;

  logic [1:0] sh_mode;
  logic [7:0] sh_factor;
  logic [1:0] act_mode;
  logic [7:0] act_factor;
  logic [7:0] grp;
  logic [7:0] count;
  logic [3:0][ACC_BITS-1:0] acc;

  logic       rise;
  logic       take;
  logic [1:0] cur_mode;
  logic [7:0] cur_factor;
  logic [7:0] cur_g;
  logic [2:0] shift;
  logic [7:0] avg_d1;
  logic [3:0][ACC_BITS-1:0] cur_acc;
  logic [3:0][ACC_BITS-1:0] sum;
  logic [3:0][ACC_BITS-1:0] shifted;
  logic [3:0][ACC_BITS-1:0] acc_next;
  logic [7:0]  g_next;
  logic        emit;
  logic [31:0] out_word;
  logic [31:0] avg_word;

  logic       wb_req;
  logic [7:0] rdata;
  logic       adr_unused;

  assign adr_unused = ^wb_adr_i[15:2];

  // The rise cycle already uses the freshly captured config and a cleared group.
  assign rise       = sq_active && (state == IDLE);
  assign take       = sq_active && sample_in_avail;
  assign cur_mode   = rise ? sh_mode : act_mode;
  assign cur_factor = rise ? sh_factor : act_factor;
  assign cur_g      = rise ? 8'd0 : grp;
  assign cur_acc    = rise ? '0 : acc;
  assign shift      = cur_factor[2:0];
  assign avg_d1     = (8'd1 << shift) - 8'd1;

  // Lane sums and the truncated average for the group-closing word
  always_comb begin
    sum      = '0;
    shifted  = '0;
    avg_word = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = cur_acc[i]
             + {{(ACC_BITS-8){1'b0}}, sample_in[8*i +: 8]};
      shifted[i] = sum[i] >> shift;
      avg_word[8*i +: 8] = shifted[i][7:0];
    end
  end

  // Per-word decimation decision and next group/accumulator state
  always_comb begin
    emit     = 1'b0;
    out_word = sample_in;
    g_next   = cur_g;
    acc_next = cur_acc;
    if (take) begin
      unique case (cur_mode)
        2'd1: begin
          emit   = (cur_g == 8'd0);
          g_next = (cur_g == cur_factor) ? 8'd0 : cur_g + 8'd1;
        end
        2'd2: begin
          if (cur_g == avg_d1) begin
            emit     = 1'b1;
            out_word = avg_word;
            g_next   = 8'd0;
            acc_next = '0;
          end else begin
            g_next   = cur_g + 8'd1;
            acc_next = sum;
          end
        end
        default: emit = 1'b1;
      endcase
    end
  end

  // Run/idle FSM with registered sample outputs and output counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      act_mode     <= 2'd0;
      act_factor   <= 8'd0;
      grp          <= 8'd0;
      acc          <= '0;
      count        <= 8'd0;
      sample       <= 32'd0;
      sample_avail <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (sq_active) state <= RUN;
        RUN:  if (!sq_active) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (rise) begin
        act_mode   <= sh_mode;
        act_factor <= sh_factor;
      end
      if (sq_active) begin
        grp <= g_next;
        acc <= acc_next;
      end else begin
        grp <= 8'd0;
        acc <= '0;
      end
      sample_avail <= emit;
      if (emit) sample <= out_word;
      count <= (rise ? 8'd0 : count) + {7'd0, emit};
    end
  end

  assign wb_req = wb_stb_i & wb_cyc_i & ~wb_ack_o;

  // Register read mux
  always_comb begin
    rdata = 8'd0;
    unique case (wb_adr_i[1:0])
      2'd0:    rdata = {6'd0, sh_mode};
      2'd1:    rdata = sh_factor;
      2'd2:    rdata = count;
      default: rdata = 8'd0;
    endcase
  end

  // Wishbone slave: shadow writes, one-cycle registered ack and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 8'd0;
      sh_mode   <= 2'd0;
      sh_factor <= 8'd0;
    end else begin
      wb_ack_o <= wb_req;
      wb_dat_o <= wb_req ? rdata : 8'd0;
      if (wb_req && wb_we_i) begin
        if (wb_adr_i[1:0] == 2'd0) sh_mode <= wb_dat_i[1:0];
        if (wb_adr_i[1:0] == 2'd1) sh_factor <= wb_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_sampdecim.sv
// tb_sampdecim: directed self-checking bench for the sample decimator.
// Each scenario task drives stimulus and checks hand-computed results.
module tb_sampdecim;

  logic        clk = 1'b0;
  logic        rst;
  logic        sq_active;
  logic [31:0] sample_in;
  logic        sample_in_avail;
  logic [31:0] sample;
  logic        sample_avail;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] outq[$];
  int          outc[$];

  sampdecim dut (
    .clk(clk),
    .rst(rst),
    .sq_active(sq_active),
    .sample_in(sample_in),
    .sample_in_avail(sample_in_avail),
    .sample(sample),
    .sample_avail(sample_avail),
    .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_avail === 1'b1) begin
      outq.push_back(sample);
      outc.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    sample_in = w;
    sample_in_avail = 1'b1;
    tick();
    sample_in_avail = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [7:0] d);
    wb_adr_i = {14'd0, a};
    wb_dat_i = d;
    wb_we_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    tick();
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i = 1'b0;
    tick();
  endtask

  task automatic wb_rd(input logic [1:0] a, output logic [7:0] d);
    wb_adr_i = {14'd0, a};
    wb_we_i = 1'b0;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    tick();
    d = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    tick();
  endtask

  task automatic flush;
    outq.delete();
    outc.delete();
  endtask

  task automatic go_up;
    sq_active = 1'b1;
    tick();
  endtask

  task automatic go_down;
    sq_active = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (sample !== 32'd0 || sample_avail !== 1'b0) begin
      bad++;
      $display("FAIL reset_sample got=%h/%b exp=0/0", sample, sample_avail);
    end
    total++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 8'd0) begin
      bad++;
      $display("FAIL reset_wb got=%b/%h exp=0/00", wb_ack_o, wb_dat_o);
    end
    rst = 1'b0;
    tick();
    for (int a = 0; a < 3; a++) begin
      wb_rd(a[1:0], d);
      total++;
      if (d !== 8'd0) begin
        bad++;
        $display("FAIL reset_reg%0d got=%h exp=00", a, d);
      end
    end
  endtask

  task automatic test_pass;
    logic [7:0] d;
    int c0;
    flush();
    go_up();
    c0 = cyc;
    send(32'h03020100);
    send(32'h07060504);
    tick();
    total++;
    if (outq.size() != 2) begin
      bad++;
      $display("FAIL pass_count got=%0d exp=2", outq.size());
    end else begin
      total++;
      if (outq[0] !== 32'h03020100 || outq[1] !== 32'h07060504) begin
        bad++;
        $display("FAIL pass_data got=%h,%h exp=03020100,07060504",
                 outq[0], outq[1]);
      end
      total++;
      if (outc[0] != c0 + 1 || outc[1] != c0 + 2) begin
        bad++;
        $display("FAIL pass_latency got=%0d,%0d exp=%0d,%0d",
                 outc[0], outc[1], c0 + 1, c0 + 2);
      end
    end
    total++;
    if (sample !== 32'h07060504) begin
      bad++;
      $display("FAIL pass_hold got=%h exp=07060504", sample);
    end
    wb_rd(2'd2, d);
    total++;
    if (d !== 8'd2) begin
      bad++;
      $display("FAIL pass_outcount got=%0d exp=2", d);
    end
    go_down();
  endtask

  task automatic test_pick;
    logic [7:0] d;
    int c0;
    wb_wr(2'd0, 8'd1);
    wb_wr(2'd1, 8'd2);
    flush();
    go_up();
    c0 = cyc;
    for (int i = 0; i < 9; i++) send(32'(i));
    tick();
    total++;
    if (outq.size() != 3) begin
      bad++;
      $display("FAIL pick_count got=%0d exp=3", outq.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (outq[k] !== 32'(3 * k) || outc[k] != c0 + 3 * k + 1) begin
          bad++;
          $display("FAIL pick_out%0d got=%h@%0d exp=%h@%0d", k,
                   outq[k], outc[k], 32'(3 * k), c0 + 3 * k + 1);
        end
      end
    end
    wb_rd(2'd2, d);
    total++;
    if (d !== 8'd3) begin
      bad++;
      $display("FAIL pick_outcount got=%0d exp=3", d);
    end
    go_down();
  endtask

  task automatic test_average;
    int c0;
    wb_wr(2'd0, 8'd2);
    wb_wr(2'd1, 8'd2);
    flush();
    go_up();
    send(32'h0A0A0A0A);
    send(32'h0B0B0B0B);
    send(32'h0C0C0C0C);
    send(32'h0E0E0E0E);
    tick();
    total++;
    if (outq.size() != 1 || outq[0] !== 32'h0B0B0B0B) begin
      bad++;
      $display("FAIL avg4 got=%0d words first=%h exp=1 word 0b0b0b0b",
               outq.size(), outq[0]);
    end
    go_down();
    wb_wr(2'd1, 8'd1);
    flush();
    go_up();
    send(32'h00FF0103);
    send(32'h00FF0204);
    tick();
    total++;
    if (outq.size() != 1 || outq[0] !== 32'h00FF0103) begin
      bad++;
      $display("FAIL avg_lanes got=%0d words first=%h exp=1 word 00ff0103",
               outq.size(), outq[0]);
    end
    go_down();
    wb_wr(2'd1, 8'd7);
    flush();
    go_up();
    c0 = cyc;
    repeat (128) send(32'hFFFFFFFF);
    tick();
    total++;
    if (outq.size() != 1 || outq[0] !== 32'hFFFFFFFF
        || outc[0] != c0 + 128) begin
      bad++;
      $display("FAIL avg128 got=%0d words first=%h@%0d exp=1 word ffffffff@%0d",
               outq.size(), outq[0], outc[0], c0 + 128);
    end
    go_down();
  endtask

  task automatic test_abort;
    wb_wr(2'd1, 8'd3);
    flush();
    go_up();
    repeat (5) send(32'h10101010);
    go_down();
    tick();
    total++;
    if (outq.size() != 0) begin
      bad++;
      $display("FAIL abort_partial got=%0d words exp=0", outq.size());
    end
    go_up();
    repeat (8) send(32'h20202020);
    tick();
    total++;
    if (outq.size() != 1 || outq[0] !== 32'h20202020) begin
      bad++;
      $display("FAIL abort_regroup got=%0d words first=%h exp=1 word 20202020",
               outq.size(), outq[0]);
    end
    go_down();
  endtask

  task automatic test_shadow;
    logic [7:0] d;
    wb_wr(2'd0, 8'd0);
    wb_wr(2'd1, 8'd0);
    flush();
    go_up();
    send(32'hA0000001);
    wb_wr(2'd0, 8'd1);
    wb_wr(2'd1, 8'd1);
    send(32'hA0000002);
    send(32'hA0000003);
    send(32'hA0000004);
    tick();
    total++;
    if (outq.size() != 4 || outq[3] !== 32'hA0000004) begin
      bad++;
      $display("FAIL shadow_pass got=%0d words last=%h exp=4 words a0000004",
               outq.size(), outq[outq.size() - 1]);
    end
    wb_rd(2'd0, d);
    total++;
    if (d !== 8'd1) begin
      bad++;
      $display("FAIL shadow_mode_rd got=%h exp=01", d);
    end
    wb_rd(2'd1, d);
    total++;
    if (d !== 8'd1) begin
      bad++;
      $display("FAIL shadow_factor_rd got=%h exp=01", d);
    end
    go_down();
    flush();
    go_up();
    send(32'hB0000001);
    send(32'hB0000002);
    send(32'hB0000003);
    send(32'hB0000004);
    tick();
    total++;
    if (outq.size() != 2 || outq[0] !== 32'hB0000001
        || outq[1] !== 32'hB0000003) begin
      bad++;
      $display("FAIL shadow_pick got=%0d words %h,%h exp=b0000001,b0000003",
               outq.size(), outq[0], outq[1]);
    end
    go_down();
  endtask

  task automatic test_same_cycle;
    logic [7:0] d;
    flush();
    sq_active = 1'b1;
    sample_in = 32'hC0000000;
    sample_in_avail = 1'b1;
    wb_adr_i = 16'd0;
    wb_dat_i = 8'd0;
    wb_we_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    tick();
    sample_in_avail = 1'b0;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i = 1'b0;
    send(32'hC0000001);
    send(32'hC0000002);
    send(32'hC0000003);
    tick();
    total++;
    if (outq.size() != 2 || outq[0] !== 32'hC0000000
        || outq[1] !== 32'hC0000002) begin
      bad++;
      $display("FAIL rise_word got=%0d words %h,%h exp=c0000000,c0000002",
               outq.size(), outq[0], outq[1]);
    end
    sq_active = 1'b0;
    sample_in = 32'hC0000004;
    sample_in_avail = 1'b1;
    tick();
    sample_in_avail = 1'b0;
    tick();
    total++;
    if (outq.size() != 2) begin
      bad++;
      $display("FAIL fall_word got=%0d words exp=2", outq.size());
    end
    wb_rd(2'd0, d);
    total++;
    if (d !== 8'd0) begin
      bad++;
      $display("FAIL rise_write_rd got=%h exp=00", d);
    end
    go_up();
    send(32'hC0000005);
    tick();
    total++;
    if (outq.size() != 3 || outq[2] !== 32'hC0000005) begin
      bad++;
      $display("FAIL rise_write_apply got=%0d words last=%h exp=3 c0000005",
               outq.size(), outq[outq.size() - 1]);
    end
    go_down();
  endtask

  task automatic test_async_reset;
    logic [7:0] d;
    wb_wr(2'd0, 8'd2);
    wb_wr(2'd1, 8'd2);
    go_up();
    send(32'h11111111);
    send(32'h22222222);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (sample !== 32'd0 || sample_avail !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_group got=%h/%b exp=0/0", sample, sample_avail);
    end
    sq_active = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    wb_wr(2'd0, 8'd2);
    wb_adr_i = 16'd0;
    wb_we_i = 1'b0;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    tick();
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    total++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 8'd2) begin
      bad++;
      $display("FAIL rst_pre_ack got=%b/%h exp=1/02", wb_ack_o, wb_dat_o);
    end
    rst = 1'b1;
    #1;
    total++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 8'd0) begin
      bad++;
      $display("FAIL rst_during_ack got=%b/%h exp=0/00", wb_ack_o, wb_dat_o);
    end
    tick();
    rst = 1'b0;
    tick();
    wb_rd(2'd0, d);
    total++;
    if (d !== 8'd0) begin
      bad++;
      $display("FAIL rst_mode_rd got=%h exp=00", d);
    end
    flush();
    go_up();
    send(32'h33333333);
    send(32'h44444444);
    tick();
    total++;
    if (outq.size() != 2 || outq[0] !== 32'h33333333
        || outq[1] !== 32'h44444444) begin
      bad++;
      $display("FAIL rst_resume got=%0d words %h,%h exp=33333333,44444444",
               outq.size(), outq[0], outq[1]);
    end
    go_down();
  endtask

  initial begin
    rst = 1'b1;
    sq_active = 1'b0;
    sample_in = 32'd0;
    sample_in_avail = 1'b0;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i = 1'b0;
    wb_adr_i = 16'd0;
    wb_dat_i = 8'd0;
    test_reset();
    test_pass();
    test_pick();
    test_average();
    test_abort();
    test_shadow();
    test_same_cycle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
